// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one datapath ALU between two requesters.
// Operands are registered into the ALU; the result is held until accepted.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             Req0Valid,
  input  logic [WIDTH-1:0] Req0SrcA,
  input  logic [WIDTH-1:0] Req0SrcB,
  input  logic [2:0]       Req0Ctrl,
  output logic             Req0Ready,
  input  logic             Req1Valid,
  input  logic [WIDTH-1:0] Req1SrcA,
  input  logic [WIDTH-1:0] Req1SrcB,
  input  logic [2:0]       Req1Ctrl,
  output logic             Req1Ready,
  output logic [WIDTH-1:0] SrcA,
  output logic [WIDTH-1:0] SrcB,
  output logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] ALUResult,
  input  logic             ALUFlags,
  output logic             RespValid0,
  output logic             RespValid1,
  output logic [WIDTH-1:0] RespResult,
  output logic             RespZero,
  input  logic             RespReady0,
  input  logic             RespReady1
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t state, state_nxt;
  logic   owner, lastgrant;
  logic   own_ready, accept;
  logic   any, sel, take;

  always_comb begin
    own_ready = owner ? RespReady1 : RespReady0;
    accept    = (state == IDLE) ||
                ((state == RESP) && own_ready);
    any       = Req0Valid | Req1Valid;
    // On a tie the requester that did not win last time goes next
    sel       = (Req0Valid && Req1Valid) ? ~lastgrant
                                         : Req1Valid;
    take      = accept & any & reset_n;
    Req0Ready = take & ~sel;
    Req1Ready = take & sel;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (take) state_nxt = EXEC;
      EXEC: state_nxt = RESP;
      RESP: begin
        if (take)           state_nxt = EXEC;
        else if (own_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      lastgrant  <= 1'b1;
      SrcA       <= '0;
      SrcB       <= '0;
      ALUControl <= 3'b000;
      RespValid0 <= 1'b0;
      RespValid1 <= 1'b0;
      RespResult <= '0;
      RespZero   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take) begin
        SrcA       <= sel ? Req1SrcA : Req0SrcA;
        SrcB       <= sel ? Req1SrcB : Req0SrcB;
        ALUControl <= sel ? Req1Ctrl : Req0Ctrl;
        owner      <= sel;
        lastgrant  <= sel;
      end
      if (state == EXEC) begin
        RespResult <= ALUResult;
        RespZero   <= ALUFlags;
        RespValid0 <= ~owner;
        RespValid1 <= owner;
      end
      if ((state == RESP) && own_ready) begin
        RespValid0 <= 1'b0;
        RespValid1 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU.
// Inputs change and outputs are sampled around the falling edge.
module tb_alu_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         Req0Valid, Req1Valid;
  logic [W-1:0] Req0SrcA, Req0SrcB;
  logic [W-1:0] Req1SrcA, Req1SrcB;
  logic [2:0]   Req0Ctrl, Req1Ctrl;
  logic         Req0Ready, Req1Ready;
  logic [W-1:0] SrcA, SrcB;
  logic [2:0]   ALUControl;
  logic [W-1:0] ALUResult;
  logic         ALUFlags;
  logic         RespValid0, RespValid1;
  logic [W-1:0] RespResult;
  logic         RespZero;
  logic         RespReady0, RespReady1;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .Req0Valid  (Req0Valid),
    .Req0SrcA   (Req0SrcA),
    .Req0SrcB   (Req0SrcB),
    .Req0Ctrl   (Req0Ctrl),
    .Req0Ready  (Req0Ready),
    .Req1Valid  (Req1Valid),
    .Req1SrcA   (Req1SrcA),
    .Req1SrcB   (Req1SrcB),
    .Req1Ctrl   (Req1Ctrl),
    .Req1Ready  (Req1Ready),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ALUControl (ALUControl),
    .ALUResult  (ALUResult),
    .ALUFlags   (ALUFlags),
    .RespValid0 (RespValid0),
    .RespValid1 (RespValid1),
    .RespResult (RespResult),
    .RespZero   (RespZero),
    .RespReady0 (RespReady0),
    .RespReady1 (RespReady1)
  );

  always_comb begin
    ALUResult = '0;
    case (ALUControl)
      3'b000:  ALUResult = SrcA + SrcB;
      3'b001:  ALUResult = SrcA - SrcB;
      3'b010:  ALUResult = SrcB;
      3'b011:  ALUResult = SrcA - SrcB;
      3'b100:  ALUResult = SrcA & SrcB;
      default: ALUResult = SrcA | SrcB;
    endcase
    ALUFlags = (ALUResult == '0);
  end

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset_n    = 1'b0;
    Req0Valid  = 0; Req1Valid = 0;
    Req0SrcA   = 0; Req0SrcB  = 0; Req0Ctrl = 0;
    Req1SrcA   = 0; Req1SrcB  = 0; Req1Ctrl = 0;
    RespReady0 = 0; RespReady1 = 0;
    step(); step();
    #1;
    chk("rst_srca", SrcA, 0);
    chk("rst_ctrl", 32'(ALUControl), 0);
    chk("rst_rv0", 32'(RespValid0), 0);
    chk("rst_rv1", 32'(RespValid1), 0);
    chk("rst_res", RespResult, 0);
    reset_n = 1'b1;

    // single ADD on requester 0
    step();
    Req0Valid = 1; Req0SrcA = 5; Req0SrcB = 3;
    Req0Ctrl = 3'b000;
    #1;
    chk("add_rdy0", 32'(Req0Ready), 1);
    chk("add_rdy1", 32'(Req1Ready), 0);
    step();
    Req0Valid = 0;
    #1;
    chk("add_srca", SrcA, 5);
    chk("add_exec_rv0", 32'(RespValid0), 0);
    chk("add_exec_rdy0", 32'(Req0Ready), 0);
    step();
    #1;
    chk("add_rv0", 32'(RespValid0), 1);
    chk("add_rv1", 32'(RespValid1), 0);
    chk("add_res", RespResult, 8);
    chk("add_zero", 32'(RespZero), 0);
    RespReady0 = 1;
    step();
    RespReady0 = 0;
    #1;
    chk("add_clr", 32'(RespValid0), 0);

    // CMP on requester 1
    Req1Valid = 1; Req1SrcA = 7; Req1SrcB = 7;
    Req1Ctrl = 3'b011;
    #1;
    chk("cmp_rdy1", 32'(Req1Ready), 1);
    step();
    Req1Valid = 0;
    step();
    #1;
    chk("cmp_rv1", 32'(RespValid1), 1);
    chk("cmp_rv0", 32'(RespValid0), 0);
    chk("cmp_res", RespResult, 0);
    chk("cmp_zero", 32'(RespZero), 1);
    RespReady1 = 1;
    step();
    RespReady1 = 0;
    #1;
    chk("cmp_clr", 32'(RespValid1), 0);

    // backpressure on requester 0's response
    Req0Valid = 1; Req0SrcA = 10; Req0SrcB = 20;
    Req0Ctrl = 3'b000;
    step();
    Req0Valid = 0;
    step();
    Req1Valid = 1; Req1SrcA = 1; Req1SrcB = 2;
    Req1Ctrl = 3'b000;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_rdy1", 32'(Req1Ready), 0);
      chk("bp_rv0", 32'(RespValid0), 1);
      chk("bp_res", RespResult, 30);
      step();
    end
    RespReady0 = 1;
    #1;
    chk("bp_release_rdy1", 32'(Req1Ready), 1);
    step();
    Req1Valid = 0; RespReady0 = 0;
    #1;
    chk("bp_exec_rv0", 32'(RespValid0), 0);
    chk("bp_exec_srca", SrcA, 1);
    chk("bp_exec_rv1", 32'(RespValid1), 0);
    step();
    #1;
    chk("bp_rv1", 32'(RespValid1), 1);
    chk("bp_res1", RespResult, 3);
    RespReady1 = 1;
    step();
    RespReady1 = 0;

    // reset during EXEC
    Req1Valid = 1; Req1SrcA = 4; Req1SrcB = 5;
    Req1Ctrl = 3'b100;
    step();
    Req1Valid = 0;
    #1;
    chk("mid_pre_srca", SrcA, 4);
    reset_n = 0;
    #1;
    chk("mid_srca", SrcA, 0);
    chk("mid_srcb", SrcB, 0);
    chk("mid_res", RespResult, 0);
    chk("mid_rv1", 32'(RespValid1), 0);
    step();
    reset_n = 1;

    // contention with both responses always accepted
    RespReady0 = 1; RespReady1 = 1;
    Req0Valid = 1; Req0SrcA = 2; Req0SrcB = 2;
    Req0Ctrl = 3'b000;
    Req1Valid = 1; Req1SrcA = 9; Req1SrcB = 4;
    Req1Ctrl = 3'b001;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("ct_rdy0", 32'(Req0Ready), 32'(i % 4 == 0));
      chk("ct_rdy1", 32'(Req1Ready), 32'(i % 4 == 2));
      chk("ct_rv0", 32'(RespValid0), 32'(i % 4 == 2));
      chk("ct_rv1", 32'(RespValid1),
          32'(i % 4 == 0 && i >= 4));
      if (i % 4 == 2) chk("ct_res0", RespResult, 4);
      if (i == 4)     chk("ct_res1", RespResult, 5);
      step();
    end
    Req0Valid = 0; Req1Valid = 0;
    step(); step();
    RespReady0 = 0; RespReady1 = 0;

    // MOV passthrough
    Req0Valid = 1; Req0SrcA = 32'h1111;
    Req0SrcB = 32'hDEADBEEF; Req0Ctrl = 3'b010;
    #1;
    chk("mov_rdy0", 32'(Req0Ready), 1);
    step();
    Req0Valid = 0;
    step();
    #1;
    chk("mov_rv0", 32'(RespValid0), 1);
    chk("mov_res", RespResult, 32'hDEADBEEF);
    chk("mov_ctrl", 32'(ALUControl), 2);
    step();
    #1;
    chk("mov_hold_rv0", 32'(RespValid0), 1);
    chk("mov_hold_ctrl", 32'(ALUControl), 2);
    RespReady0 = 1;
    step();
    RespReady0 = 0;
    #1;
    chk("mov_clr", 32'(RespValid0), 0);
    chk("mov_idle_ctrl", 32'(ALUControl), 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
